pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 126 ++++++++++++
 tb/tb_pwm_capture.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM high-time / period capture with a valid/ready result port, overrun
// and stuck-input detection. All timing is in clkCore cycles.
module pwm_capture #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clkCore,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_cnt,
  output logic [WIDTH-1:0] period_cnt,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  state_t                 r_state;
  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_high;

  logic w_sync;
  logic w_rise;
  logic w_fall;
  logic w_accept;
  logic w_cnt_max;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_sync & ~r_hist;
  assign w_fall    = ~w_sync & r_hist;
  assign w_accept  = valid & ready;
  assign w_cnt_max = (r_cnt == CNT_MAX);

  always_ff @(posedge clkCore or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_hist <= w_sync;
    end
  end

  always_ff @(posedge clkCore or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_high      <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      valid       <= 1'b0;
      overrun     <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else if (!en) begin
      // Result port is frozen while disabled; only the flags are cleared.
      r_state <= S_IDLE;
      r_cnt   <= '0;
      overrun <= 1'b0;
      stuck   <= 1'b0;
    end else begin
      if (r_state != S_IDLE) begin
        if (w_rise)
          r_cnt <= CNT_ONE;
        else if (!w_cnt_max)
          r_cnt <= r_cnt + CNT_ONE;
      end

      if (w_accept)
        valid <= 1'b0;

      if (w_rise || w_fall)
        stuck <= 1'b0;

      case (r_state)
        S_IDLE: r_state <= S_ARM;

        S_ARM: begin
          if (w_rise)
            r_state <= S_HIGH;
        end

        S_HIGH: begin
          if (w_fall) begin
            r_high  <= r_cnt;
            r_state <= S_LOW;
          end else if (w_cnt_max) begin
            stuck       <= 1'b1;
            stuck_level <= w_sync;
            r_state     <= S_ARM;
          end
        end

        S_LOW: begin
          if (w_rise) begin
            // A publish overrides the accept-clear above in the same cycle.
            if (!valid || ready) begin
              high_cnt   <= r_high;
              period_cnt <= r_cnt;
              valid      <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            r_state <= S_HIGH;
          end else if (w_cnt_max) begin
            stuck       <= 1'b1;
            stuck_level <= w_sync;
            r_state     <= S_ARM;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: scoreboard of expected results,
// popped whenever the DUT hands a result over (valid & ready).
`timescale 1ns/100ps
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int SYNC = 2;

  typedef struct {
    int hi;
    int per;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         pwm_in;
  logic         ready;
  logic [W-1:0] high_cnt;
  logic [W-1:0] period_cnt;
  logic         valid;
  logic         overrun;
  logic         stuck;
  logic         stuck_level;

  exp_t sb[$];
  exp_t e_mon;
  int   n_total  = 0;
  int   n_bad    = 0;
  int   cyc      = 0;
  int   exp_gap  = 0;
  int   last_acc = -1;
  int   prev_hi  = 0;
  int   prev_per = 0;

  pwm_capture #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clkCore    (clk),
    .reset      (rst),
    .en         (en),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .ready      (ready),
    .overrun    (overrun),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  always #2.5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restart(input logic rdy);
    pwm_in = 1'b0;
    en     = 1'b0;
    ready  = rdy;
    step(3);
    en = 1'b1;
    step(2);
  endtask

  // One PWM period starting with a rising edge. pub: that edge publishes the
  // previous period. rdy_edge: raise ready that many edges after the rise.
  task automatic pwm_period(input int hi, input int lo, input bit pub,
                            input int rdy_edge, input bit lat);
    int lat_i = 0;
    if (pub) sb.push_back('{hi: prev_hi, per: prev_per});
    pwm_in = 1'b1;
    for (int i = 1; i <= hi; i++) begin
      @(posedge clk);
      #1;
      if (lat && lat_i == 0 && valid) lat_i = i;
      if (rdy_edge != 0 && i == rdy_edge) ready = 1'b1;
      if (rdy_edge != 0 && i == rdy_edge + 1) begin
        check("acc_pub_valid", int'(valid), 1);
        check("acc_pub_high", int'(high_cnt), prev_hi);
      end
    end
    if (lat) check("latency_edges", lat_i, SYNC + 1);
    pwm_in = 1'b0;
    step(lo);
    prev_hi  = hi;
    prev_per = hi + lo;
  endtask

  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", int'(valid), 0);
      end else begin
        e_mon = sb.pop_front();
        check("high_cnt", int'(high_cnt), e_mon.hi);
        check("period_cnt", int'(period_cnt), e_mon.per);
        if (exp_gap != 0 && last_acc >= 0) check("valid_gap", cyc - last_acc, exp_gap);
        last_acc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; ready = 1'b0; pwm_in = 1'b0;
    #1;
    check("rst_valid", int'(valid), 0);
    check("rst_high", int'(high_cnt), 0);
    check("rst_period", int'(period_cnt), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_stuck", int'(stuck), 0);
    step(2);
    rst = 1'b0;

    // Continuous 30/70 stream, always ready
    restart(1'b1);
    exp_gap = 100; last_acc = -1;
    pwm_period(30, 70, 0, 0, 0);
    check("arm_no_publish", int'(valid), 0);
    pwm_period(30, 70, 1, 0, 1);
    for (int k = 0; k < 3; k++) pwm_period(30, 70, 1, 0, 0);
    exp_gap = 0; last_acc = -1;

    // Back-pressure and overrun
    restart(1'b0);
    pwm_period(25, 75, 0, 0, 0);
    pwm_period(25, 75, 1, 0, 0);
    check("ovr_first_valid", int'(valid), 1);
    check("ovr_first_flag", int'(overrun), 0);
    pwm_period(25, 75, 0, 0, 0);
    check("ovr_set", int'(overrun), 1);
    check("ovr_hold_high", int'(high_cnt), 25);
    check("ovr_hold_period", int'(period_cnt), 100);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("ovr_acc_valid", int'(valid), 0);
    check("ovr_sticky", int'(overrun), 1);
    en = 1'b0;
    step(2);
    check("ovr_clr_en", int'(overrun), 0);

    // Accept in the same cycle as a new publish
    restart(1'b0);
    pwm_period(20, 60, 0, 0, 0);
    pwm_period(40, 40, 1, 0, 0);
    pwm_period(50, 30, 1, 2, 0);
    check("acc_pub_overrun", int'(overrun), 0);

    // Stuck high
    restart(1'b1);
    pwm_in = 1'b1;
    step(257);
    check("stuck_early", int'(stuck), 0);
    step(1);
    check("stuck_set", int'(stuck), 1);
    check("stuck_level", int'(stuck_level), 1);
    check("stuck_valid", int'(valid), 0);
    step(42);
    check("stuck_hold", int'(stuck), 1);
    pwm_in = 1'b0;
    step(3);
    check("stuck_clr", int'(stuck), 0);
    prev_hi = 0; prev_per = 0;
    pwm_period(30, 70, 0, 0, 0);
    pwm_period(30, 70, 1, 0, 0);

    // Hold while disabled, then reset mid-HIGH with a pending result
    restart(1'b0);
    pwm_period(20, 60, 0, 0, 0);
    pwm_period(20, 60, 1, 0, 0);
    en = 1'b0;
    step(3);
    check("dis_hold_valid", int'(valid), 1);
    check("dis_hold_high", int'(high_cnt), 20);
    check("dis_hold_period", int'(period_cnt), 80);
    en = 1'b1;
    step(2);
    pwm_in = 1'b1;
    step(10);
    rst = 1'b1;
    pwm_in = 1'b0;
    #1;
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_high", int'(high_cnt), 0);
    check("mid_rst_period", int'(period_cnt), 0);
    sb.delete();
    step(2);
    rst = 1'b0;
    ready = 1'b1;
    step(2);
    pwm_period(30, 70, 0, 0, 0);
    check("post_rst_no_result", int'(valid), 0);
    pwm_period(30, 70, 1, 0, 0);

    // en=0 pulse mid-LOW aborts the measurement
    restart(1'b1);
    pwm_period(30, 70, 0, 0, 0);
    sb.push_back('{hi: prev_hi, per: prev_per});
    pwm_in = 1'b1;
    step(30);
    pwm_in = 1'b0;
    step(30);
    en = 1'b0;
    step(5);
    en = 1'b1;
    step(35);
    pwm_period(30, 70, 0, 0, 0);
    pwm_period(30, 70, 1, 0, 0);

    en = 1'b0;
    step(3);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
